// File: rtl/debounce_fsmd_multi_pkg.sv
// Shared definitions for the multi-channel debouncer: per-channel FSM state encoding.
// The channel module's optional input synchronizer is enabled by defining DEBOUNCE_SYNC_EN.
package debounce_fsmd_multi_pkg;

  typedef logic [1:0] db_state_t;

  // Bit 1 doubles as the debounced level, so db_level comes straight off the state register
  localparam logic [1:0] ST_ZERO  = 2'b00;
  localparam logic [1:0] ST_WAIT1 = 2'b01;
  localparam logic [1:0] ST_ONE   = 2'b10;
  localparam logic [1:0] ST_WAIT0 = 2'b11;

endpackage

// File: rtl/debounce_fsmd_ch.sv
// One debounce channel: optional 2-flop synchronizer (DEBOUNCE_SYNC_EN), 4-state FSM with
// reloadable down-counter, registered rise/fall ticks and a wrapping press counter.
module debounce_fsmd_ch
  import debounce_fsmd_multi_pkg::*;
#(
  parameter int WAIT_TICKS = 2**20,
  parameter int PCNT_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sw,
  output logic              level,
  output logic              rise,
  output logic              fall,
  output logic [PCNT_W-1:0] press_cnt
);

  localparam int CNT_W = $clog2(WAIT_TICKS);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(WAIT_TICKS - 1);

  logic sw_s;

`ifdef DEBOUNCE_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sw;
      sync2_q <= sync1_q;
    end
  end

  assign sw_s = sync2_q;
`else
  assign sw_s = sw;
`endif

  db_state_t         state_q, state_d;
  logic [CNT_W-1:0]  q_q, q_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic [PCNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      ST_ZERO: begin
        if (sw_s) begin
          state_d = ST_WAIT1;
          q_d     = RELOAD;
        end
      end
      ST_WAIT1: begin
        if (!sw_s) begin
          state_d = ST_ZERO;
        end else if (q_q != '0) begin
          q_d = q_q - 1'b1;
        end else begin
          state_d = ST_ONE;
          rise_d  = 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_ONE: begin
        if (!sw_s) begin
          state_d = ST_WAIT0;
          q_d     = RELOAD;
        end
      end
      ST_WAIT0: begin
        if (sw_s) begin
          state_d = ST_ONE;
        end else if (q_q != '0) begin
          q_d = q_q - 1'b1;
        end else begin
          state_d = ST_ZERO;
          fall_d  = 1'b1;
        end
      end
      default: state_d = ST_ZERO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ZERO;
      q_q     <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level     = state_q[1];
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign press_cnt = cnt_q;

endmodule

// File: rtl/debounce_fsmd_multi.sv
// N-channel switch debouncer: one debounce_fsmd_ch per input bit, press counters flattened.
// Define DEBOUNCE_SYNC_EN to insert a 2-flop synchronizer per input (adds 2 cycles of latency).
module debounce_fsmd_multi
  import debounce_fsmd_multi_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int WAIT_TICKS = 2**20,
  parameter int PCNT_W     = 4
) (
  input  logic                     clk_amisha,
  input  logic                     reset_amisha,
  input  logic [N_CH-1:0]          sw_amisha,
  output logic [N_CH-1:0]          db_level,
  output logic [N_CH-1:0]          db_rise,
  output logic [N_CH-1:0]          db_fall,
  output logic [N_CH*PCNT_W-1:0]   press_cnt
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_fsmd_ch #(
      .WAIT_TICKS(WAIT_TICKS),
      .PCNT_W    (PCNT_W)
    ) u_ch (
      .clk      (clk_amisha),
      .rst      (reset_amisha),
      .sw       (sw_amisha[i]),
      .level    (db_level[i]),
      .rise     (db_rise[i]),
      .fall     (db_fall[i]),
      .press_cnt(press_cnt[i*PCNT_W +: PCNT_W])
    );
  end

endmodule

// File: tb/tb_debounce_fsmd_multi.sv
// Bench for debounce_fsmd_multi: directed scenarios plus random bouncing, checked every cycle
// against a run-length model of the debouncer.
module tb_debounce_fsmd_multi;

  localparam int N_CH = 2;
  localparam int WT   = 4;
  localparam int PW   = 4;
`ifdef DEBOUNCE_SYNC_EN
  localparam int LAT = WT + 1 + 2;
`else
  localparam int LAT = WT + 1;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [N_CH-1:0]      sw  = '0;
  logic [N_CH-1:0]      db_level, db_rise, db_fall;
  logic [N_CH*PW-1:0]   press_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  debounce_fsmd_multi #(.N_CH(N_CH), .WAIT_TICKS(WT), .PCNT_W(PW)) dut (
    .clk_amisha  (clk),
    .reset_amisha(rst),
    .sw_amisha   (sw),
    .db_level    (db_level),
    .db_rise     (db_rise),
    .db_fall     (db_fall),
    .press_cnt   (press_cnt)
  );

  always #5 clk = ~clk;

  // Model: a level flips once the input has disagreed with it for WT+1 consecutive samples.
  logic [N_CH-1:0]    m_level = '0, m_rise = '0, m_fall = '0;
  logic [N_CH-1:0]    m_d1 = '0, m_d2 = '0;
  int                 m_run [N_CH];
  int                 m_press [N_CH];
  logic [N_CH*PW-1:0] m_cnt;

  task automatic model_edge(input logic [N_CH-1:0] s, input logic r);
    logic [N_CH-1:0] eff;
    if (r) begin
      m_level = '0; m_rise = '0; m_fall = '0; m_d1 = '0; m_d2 = '0;
      for (int c = 0; c < N_CH; c++) begin m_run[c] = 0; m_press[c] = 0; end
    end else begin
`ifdef DEBOUNCE_SYNC_EN
      eff  = m_d2;
      m_d2 = m_d1;
      m_d1 = s;
`else
      eff = s;
`endif
      m_rise = '0; m_fall = '0;
      for (int c = 0; c < N_CH; c++) begin
        if (eff[c] != m_level[c]) begin
          m_run[c]++;
          if (m_run[c] == WT + 1) begin
            m_level[c] = ~m_level[c];
            m_run[c]   = 0;
            if (m_level[c]) begin m_rise[c] = 1'b1; m_press[c]++; end
            else m_fall[c] = 1'b1;
          end
        end else begin
          m_run[c] = 0;
        end
      end
    end
    for (int c = 0; c < N_CH; c++) m_cnt[c*PW +: PW] = PW'(m_press[c] % (1 << PW));
  endtask

  task automatic check_outputs();
    n_cmp++;
    assert (db_level === m_level) else begin
      n_bad++; $error("FAIL db_level observed %b expected %b", db_level, m_level);
    end
    n_cmp++;
    assert (db_rise === m_rise) else begin
      n_bad++; $error("FAIL db_rise observed %b expected %b", db_rise, m_rise);
    end
    n_cmp++;
    assert (db_fall === m_fall) else begin
      n_bad++; $error("FAIL db_fall observed %b expected %b", db_fall, m_fall);
    end
    n_cmp++;
    assert (press_cnt === m_cnt) else begin
      n_bad++; $error("FAIL press_cnt observed %h expected %h", press_cnt, m_cnt);
    end
  endtask

  task automatic step(input logic [N_CH-1:0] s, input logic r);
    @(negedge clk);
    sw  = s;
    rst = r;
    @(posedge clk);
    model_edge(s, r);
    #1;
    check_outputs();
  endtask

  task automatic expect_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs == exp) else begin
      n_bad++; $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    logic [N_CH-1:0] rs;

    // 1: reset held with both inputs high
    step(2'b11, 1'b1);
    step(2'b11, 1'b1);
    expect_int("reset_all_zero", int'({db_level, db_rise, db_fall, press_cnt}), 0);

    // 2: clean press on ch0
    step(2'b00, 1'b1);
    n = 0;
    do begin step(2'b01, 1'b0); n++; end while (!db_rise[0] && n < 20);
    expect_int("ch0_rise_latency", n, LAT);
    expect_int("ch0_level_with_rise", int'(db_level[0]), 1);
    step(2'b01, 1'b0);
    expect_int("ch0_rise_one_cycle", int'(db_rise[0]), 0);
    expect_int("ch0_press_1", int'(press_cnt[PW-1:0]), 1);

    // 3: bounce then stable high
    step(2'b00, 1'b1);
    step(2'b01, 1'b0); step(2'b00, 1'b0); step(2'b01, 1'b0); step(2'b00, 1'b0);
    n = 0;
    do begin step(2'b01, 1'b0); n++; end while (!db_rise[0] && n < 20);
    expect_int("bounce_rise_latency", n, LAT);
    for (int i = 0; i < 6; i++) step(2'b01, 1'b0);
    expect_int("bounce_press_1", int'(press_cnt[PW-1:0]), 1);

    // 4: short low glitch ignored, long low produces fall
    for (int i = 0; i < 3; i++) step(2'b00, 1'b0);
    for (int i = 0; i < 4; i++) step(2'b01, 1'b0);
    expect_int("glitch_level_held", int'(db_level[0]), 1);
    n = 0;
    do begin step(2'b00, 1'b0); n++; end while (!db_fall[0] && n < 20);
    expect_int("fall_latency", n, LAT);
    step(2'b00, 1'b0);
    expect_int("fall_one_cycle", int'(db_fall[0]), 0);

    // 5: simultaneous press, then ch1 press counter wrap
    step(2'b00, 1'b1);
    n = 0;
    do begin step(2'b11, 1'b0); n++; end while (db_rise == 2'b00 && n < 20);
    expect_int("both_rise_same_cycle", int'(db_rise), 3);
    for (int p = 0; p < 16; p++) begin
      for (int i = 0; i < LAT + 1; i++) step(2'b01, 1'b0);
      for (int i = 0; i < LAT + 1; i++) step(2'b11, 1'b0);
    end
    expect_int("ch1_press_wrap", int'(press_cnt[2*PW-1:PW]), 1);
    expect_int("ch0_press_no_wrap", int'(press_cnt[PW-1:0]), 1);

    // 6: reset during WAIT1
    step(2'b00, 1'b1);
    for (int i = 0; i < 3; i++) step(2'b01, 1'b0);
    step(2'b01, 1'b1);
    expect_int("midwait_reset_zero", int'({db_level, db_rise, db_fall, press_cnt}), 0);
    n = 0;
    do begin step(2'b01, 1'b0); n++; end while (!db_rise[0] && n < 20);
    expect_int("post_reset_rise_latency", n, LAT);

    // Random bouncing with rare resets
    rs = '0;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < N_CH; c++)
        if ($urandom_range(0, 4) == 0) rs[c] = ~rs[c];
      step(rs, ($urandom_range(0, 199) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
